// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost movement datapath.
// Shared by the ghost stepper and the tile-target helper.
package ghost_pkg;

    localparam int MAZE_W     = 28;
    localparam int MAZE_H     = 31;
    localparam int NUM_GHOSTS = 4;
    localparam int ADDR_W     = 10;
    localparam int POS_W      = 5;

    typedef logic [POS_W-1:0] ghost_pos_t;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_UPDATE,
        ST_DONE
    } state_t;

    localparam ghost_pos_t GHOST_START_X [NUM_GHOSTS] = '{5'd13, 5'd11, 5'd13, 5'd15};
    localparam ghost_pos_t GHOST_START_Y [NUM_GHOSTS] = '{5'd11, 5'd14, 5'd14, 5'd14};

    // Row-major tile address; 30*28+27 = 867 is the largest value and fits in 10 bits.
    function automatic logic [ADDR_W-1:0] tile_addr(input ghost_pos_t x, input ghost_pos_t y,
                                                    input int width);
        return ADDR_W'(y) * ADDR_W'(width) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/ghost_motion_stepper_target_calc.sv
// Combinational next-tile calculator with horizontal tunnel wrap and vertical edge detection.
// Kept standalone so the player mover can reuse the same wrap rules.
module ghost_target_calc #(
    parameter int MAZE_W = ghost_pkg::MAZE_W,
    parameter int MAZE_H = ghost_pkg::MAZE_H
) (
    input  ghost_pkg::ghost_pos_t i_x,
    input  ghost_pkg::ghost_pos_t i_y,
    input  logic [2:0]            i_dir,
    output ghost_pkg::ghost_pos_t o_tx,
    output ghost_pkg::ghost_pos_t o_ty,
    output logic                  o_out_of_grid
);
    import ghost_pkg::*;

    localparam ghost_pos_t X_LAST = POS_W'(MAZE_W - 1);
    localparam ghost_pos_t Y_LAST = POS_W'(MAZE_H - 1);

    // NOTE: every output gets a default before the case, so no path through
    // this block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        o_tx          = i_x;
        o_ty          = i_y;
        o_out_of_grid = 1'b0;
        case (i_dir)
            DIR_UP: begin
                if (i_y == '0) o_out_of_grid = 1'b1;
                else           o_ty          = i_y - 5'd1;
            end
            DIR_DOWN: begin
                if (i_y == Y_LAST) o_out_of_grid = 1'b1;
                else               o_ty          = i_y + 5'd1;
            end
            DIR_LEFT:  o_tx = (i_x == '0)     ? X_LAST : i_x - 5'd1;
            DIR_RIGHT: o_tx = (i_x == X_LAST) ? '0     : i_x + 5'd1;
            default: ;
        endcase
    end

endmodule

// File: rtl/ghost_motion_stepper.sv
// Frame-divided ghost mover: each sweep checks the wall memory for every ghost's
// target tile in turn, then moves the ghost or marks it blocked.
module ghost_motion_stepper #(
    parameter int MAZE_W   = ghost_pkg::MAZE_W,
    parameter int MAZE_H   = ghost_pkg::MAZE_H,
    parameter int MOVE_DIV = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_tick,
    input  logic             restart,
    input  logic [3:0][2:0]  ghost_dir,
    output logic [9:0]       maze_addr,
    input  logic             maze_wall,
    output logic [3:0][4:0]  ghost_x,
    output logic [3:0][4:0]  ghost_y,
    output logic [3:0]       ghost_blocked,
    output logic             step_done,
    output logic             overrun
);
    import ghost_pkg::*;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [7:0]              r_div;
    logic [1:0]              r_g;
    logic [3:0][2:0]         r_dir;
    ghost_pos_t [3:0]        r_x;
    ghost_pos_t [3:0]        r_y;
    logic [3:0]              r_blocked;
    logic                    r_overrun;
    logic [ADDR_W-1:0]       r_maze_addr;

    logic [2:0]              w_cur_dir;
    ghost_pos_t              w_tx;
    ghost_pos_t              w_ty;
    logic                    w_out_of_grid;
    logic [ADDR_W-1:0]       w_tile_addr;
    logic                    w_in_idle;
    logic                    w_sweep_start;
    logic                    w_dir_active;
    logic                    w_move;

    assign w_cur_dir     = r_dir[r_g];
    assign w_in_idle     = (r_state == ST_IDLE);
    assign w_sweep_start = w_in_idle && frame_tick && !restart && (r_div == 8'(MOVE_DIV - 1));
    assign w_dir_active  = (w_cur_dir >= DIR_UP) && (w_cur_dir <= DIR_RIGHT);
    assign w_move        = w_dir_active && !maze_wall && !w_out_of_grid;
    assign w_tile_addr   = tile_addr(w_tx, w_ty, MAZE_W);

    ghost_target_calc #(
        .MAZE_W (MAZE_W),
        .MAZE_H (MAZE_H)
    ) u_target (
        .i_x           (r_x[r_g]),
        .i_y           (r_y[r_g]),
        .i_dir         (w_cur_dir),
        .o_tx          (w_tx),
        .o_ty          (w_ty),
        .o_out_of_grid (w_out_of_grid)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_sweep_start) w_state_next = ST_ADDR;
            ST_ADDR:   w_state_next = ST_WAIT;
            ST_WAIT:   w_state_next = ST_UPDATE;
            ST_UPDATE: w_state_next = (r_g == 2'd3) ? ST_DONE : ST_ADDR;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
        if (restart) w_state_next = ST_IDLE;
    end

    // Address is live during ADDR and held from the register through WAIT/UPDATE.
    always_comb begin
        step_done = (r_state == ST_DONE);
        maze_addr = (r_state == ST_ADDR) ? w_tile_addr : r_maze_addr;
    end

    // NOTE: the position table is only eight 5-bit registers, so it is reset
    // explicitly rather than treated as an uninitialised memory.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                r_x[i] <= GHOST_START_X[i];
                r_y[i] <= GHOST_START_Y[i];
            end
            r_blocked   <= '0;
            r_overrun   <= 1'b0;
            r_div       <= '0;
            r_g         <= '0;
            r_dir       <= '0;
            r_maze_addr <= '0;
        end else if (restart) begin
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                r_x[i] <= GHOST_START_X[i];
                r_y[i] <= GHOST_START_Y[i];
            end
            r_blocked   <= '0;
            r_overrun   <= 1'b0;
            r_div       <= '0;
            r_g         <= '0;
            r_maze_addr <= '0;
        end else begin
            if (frame_tick) begin
                if (w_in_idle) r_div <= (r_div == 8'(MOVE_DIV - 1)) ? 8'd0 : r_div + 8'd1;
                else           r_overrun <= 1'b1;
            end
            if (w_sweep_start) begin
                r_dir <= ghost_dir;
                r_g   <= '0;
            end
            if (r_state == ST_ADDR) r_maze_addr <= w_tile_addr;
            if (r_state == ST_UPDATE) begin
                if (w_move) begin
                    r_x[r_g] <= w_tx;
                    r_y[r_g] <= w_ty;
                end
                r_blocked[r_g] <= w_dir_active && !w_move;
                if (r_g != 2'd3) r_g <= r_g + 2'd1;
            end
        end
    end

    assign ghost_x       = r_x;
    assign ghost_y       = r_y;
    assign ghost_blocked = r_blocked;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_ghost_motion_stepper.sv
// Directed bench: a MOVE_DIV=1 instance for movement/timing and a MOVE_DIV=8
// instance for the frame divider and overrun flag.
module tb_ghost_motion_stepper;

    logic            Clk = 1'b0;
    logic            Reset_n = 1'b0;
    logic            restart = 1'b0;
    logic            frame_tick = 1'b0;
    logic            frame_tick8 = 1'b0;
    logic [3:0][2:0] ghost_dir = '0;

    logic [9:0]      maze_addr, maze_addr8;
    logic            maze_wall = 1'b0;
    logic [3:0][4:0] ghost_x, ghost_y, ghost_x8, ghost_y8;
    logic [3:0]      ghost_blocked, ghost_blocked8;
    logic            step_done, step_done8, overrun, overrun8;

    logic            wall_en = 1'b0;
    logic [9:0]      wall_addr = '0;
    int              n_assert = 0;
    int              n_fail = 0;
    int              n_done8 = 0;
    int              lat;
    int              pulses;

    localparam logic [19:0] START_X = {5'd15, 5'd13, 5'd11, 5'd13};
    localparam logic [19:0] START_Y = {5'd14, 5'd14, 5'd14, 5'd11};

    always #5 Clk = ~Clk;

    ghost_motion_stepper #(.MOVE_DIV(1)) u_dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_tick    (frame_tick),
        .restart       (restart),
        .ghost_dir     (ghost_dir),
        .maze_addr     (maze_addr),
        .maze_wall     (maze_wall),
        .ghost_x       (ghost_x),
        .ghost_y       (ghost_y),
        .ghost_blocked (ghost_blocked),
        .step_done     (step_done),
        .overrun       (overrun)
    );

    ghost_motion_stepper #(.MOVE_DIV(8)) u_dut8 (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_tick    (frame_tick8),
        .restart       (restart),
        .ghost_dir     (ghost_dir),
        .maze_addr     (maze_addr8),
        .maze_wall     (1'b0),
        .ghost_x       (ghost_x8),
        .ghost_y       (ghost_y8),
        .ghost_blocked (ghost_blocked8),
        .step_done     (step_done8),
        .overrun       (overrun8)
    );

    // Synchronous wall memory: one programmable wall tile, one cycle read latency.
    always @(posedge Clk) maze_wall <= wall_en && (maze_addr == wall_addr);
    always @(posedge Clk) if (step_done8) n_done8 <= n_done8 + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick_main();
        @(negedge Clk) frame_tick = 1'b1;
        @(negedge Clk) frame_tick = 1'b0;
    endtask

    task automatic tick_div();
        @(negedge Clk) frame_tick8 = 1'b1;
        @(negedge Clk) frame_tick8 = 1'b0;
    endtask

    // Negedges until step_done is seen; -1 when the bound expires.
    task automatic wait_done(input bit use_div, output int cycles);
        cycles = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge Clk);
            if ((use_div ? step_done8 : step_done) === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            if (step_done === 1'b1) cnt++;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge Clk);
        check("rst_x", ghost_x, START_X);
        check("rst_y", ghost_y, START_Y);
        check("rst_blocked", ghost_blocked, 0);
        check("rst_step_done", step_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_addr", maze_addr, 0);
        @(negedge Clk) Reset_n = 1'b1;

        // Divider: seven ticks idle, eighth starts a sweep, mid-sweep tick overruns
        repeat (7) tick_div();
        repeat (15) @(negedge Clk);
        check("div_7_ticks_no_sweep", n_done8, 0);
        tick_div();
        repeat (4) @(negedge Clk);
        tick_div();
        wait_done(1'b1, lat);
        check("div_sweep_latency", lat, 6);
        check("div_overrun", overrun8, 1);
        @(negedge Clk);
        repeat (7) tick_div();
        repeat (15) @(negedge Clk);
        check("div_overrun_tick_ignored", n_done8, 1);
        tick_div();
        wait_done(1'b1, lat);
        check("div_second_sweep_latency", lat, 12);
        check("div_addr_last_ghost", maze_addr8, 407);
        check("div_x_unchanged", ghost_x8, START_X);
        check("div_y_unchanged", ghost_y8, START_Y);
        check("div_blocked", ghost_blocked8, 0);

        // All directions none
        tick_main();
        wait_done(1'b0, lat);
        check("none_latency", lat, 12);
        @(negedge Clk);
        check("none_done_one_cycle", step_done, 0);
        check("none_x", ghost_x, START_X);
        check("none_y", ghost_y, START_Y);
        check("none_blocked", ghost_blocked, 0);
        check("none_overrun", overrun, 0);

        // Ghost0 right into open tile
        ghost_dir = {3'd0, 3'd0, 3'd0, 3'd4};
        tick_main();
        check("g0_addr_in_addr", maze_addr, 322);
        @(negedge Clk);
        check("g0_addr_in_wait", maze_addr, 322);
        @(negedge Clk);
        check("g0_x_before_update", ghost_x[0], 13);
        @(negedge Clk);
        check("g0_x_after_update", ghost_x[0], 14);
        wait_done(1'b0, lat);
        check("g0_latency", lat, 9);
        check("g0_x_all", ghost_x, {5'd15, 5'd13, 5'd11, 5'd14});
        check("g0_blocked", ghost_blocked, 0);

        // Ghost1 left into a wall
        ghost_dir = {3'd0, 3'd0, 3'd3, 3'd0};
        wall_en = 1'b1;
        wall_addr = 10'd402;
        tick_main();
        wait_done(1'b0, lat);
        check("g1_wall_x", ghost_x, {5'd15, 5'd13, 5'd11, 5'd14});
        check("g1_wall_blocked", ghost_blocked, 4'b0010);
        wall_en = 1'b0;

        // Ghost0 up to the top row, ghost1 left to column 0
        ghost_dir = {3'd0, 3'd0, 3'd3, 3'd1};
        for (int i = 0; i < 11; i++) begin
            tick_main();
            wait_done(1'b0, lat);
        end
        check("edge_x", ghost_x, {5'd15, 5'd13, 5'd0, 5'd14});
        check("edge_y", ghost_y, {5'd14, 5'd14, 5'd14, 5'd0});
        check("edge_blocked", ghost_blocked, 0);

        // Top-edge refusal for ghost0, tunnel wrap left for ghost1
        tick_main();
        check("oog_addr_current_tile", maze_addr, 14);
        repeat (3) @(negedge Clk);
        check("wrap_left_addr", maze_addr, 419);
        wait_done(1'b0, lat);
        check("wrap_left_x", ghost_x, {5'd15, 5'd13, 5'd27, 5'd14});
        check("oog_y", ghost_y, {5'd14, 5'd14, 5'd14, 5'd0});
        check("oog_blocked", ghost_blocked, 4'b0001);

        // Tunnel wrap right
        ghost_dir = {3'd0, 3'd0, 3'd4, 3'd0};
        tick_main();
        wait_done(1'b0, lat);
        check("wrap_right_x", ghost_x, {5'd15, 5'd13, 5'd0, 5'd14});
        check("wrap_right_blocked", ghost_blocked, 0);

        // Tick during a sweep sets overrun and starts nothing new
        ghost_dir = '0;
        tick_main();
        repeat (4) @(negedge Clk);
        tick_main();
        wait_done(1'b0, lat);
        check("overrun_latency", lat, 6);
        check("overrun_set", overrun, 1);
        count_pulses(20, pulses);
        check("overrun_no_extra_sweep", pulses, 0);

        // Restart during ghost2's WAIT
        ghost_dir = {3'd0, 3'd0, 3'd1, 3'd4};
        wall_en = 1'b1;
        wall_addr = 10'd364;
        tick_main();
        repeat (7) @(negedge Clk);
        check("pre_restart_x", ghost_x, {5'd15, 5'd13, 5'd0, 5'd15});
        check("pre_restart_blocked", ghost_blocked, 4'b0010);
        check("pre_restart_overrun", overrun, 1);
        restart = 1'b1;
        @(negedge Clk) restart = 1'b0;
        wall_en = 1'b0;
        check("restart_x", ghost_x, START_X);
        check("restart_y", ghost_y, START_Y);
        check("restart_blocked", ghost_blocked, 0);
        check("restart_overrun", overrun, 0);
        count_pulses(20, pulses);
        check("restart_no_step_done", pulses, 0);

        // Asynchronous reset mid-sweep
        ghost_dir = {3'd0, 3'd0, 3'd0, 3'd4};
        tick_main();
        repeat (4) @(negedge Clk);
        check("pre_reset_x", ghost_x, {5'd15, 5'd13, 5'd11, 5'd14});
        check("pre_reset_addr", maze_addr, 403);
        #2 Reset_n = 1'b0;
        #1;
        check("async_rst_x", ghost_x, START_X);
        check("async_rst_y", ghost_y, START_Y);
        check("async_rst_addr", maze_addr, 0);
        check("async_rst_blocked", ghost_blocked, 0);
        check("async_rst_step_done", step_done, 0);
        @(negedge Clk) Reset_n = 1'b1;
        count_pulses(20, pulses);
        check("post_reset_no_step_done", pulses, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ghost_motion_stepper.md
Name: ghost_motion_stepper

Overview:
- Downstream consumer of the per-ghost 3-bit direction array that the NIOS direction reader produces.
- On each frame tick, walks ghosts 0..3 in turn. For each ghost it queries the maze wall memory for the target tile, then moves the ghost one tile or holds it in place.
- Drives tile positions and blocked flags to the sprite renderer, and back toward the NIOS direction writer path.

Parameters:
- MAZE_W, 28, maze width in tiles.
- MAZE_H, 31, maze height in tiles.
- MOVE_DIV, 8, number of frame ticks per movement step (1..255).

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame (vsync-derived)
- restart  in  1  synchronous pulse: return all ghosts to start tiles, clear divider
- ghost_dir  in  [3:0][2:0]  per-ghost direction: 0 none, 1 up, 2 down, 3 left, 4 right, 5-7 treated as none
- maze_addr  out  10  wall-memory tile address, y*MAZE_W + x
- maze_wall  in  1  wall bit; valid exactly one cycle after maze_addr is presented
- ghost_x  out  [3:0][4:0]  ghost tile column
- ghost_y  out  [3:0][4:0]  ghost tile row
- ghost_blocked  out  [3:0]  set when the last attempted move was refused
- step_done  out  1  one-cycle pulse when a sweep over all four ghosts completes
- overrun  out  1  sticky; set if frame_tick arrives while a sweep is in progress

Behaviour:
- Reset values:
  - ghost_x/ghost_y = GHOST_START_X/Y: (13,11), (11,14), (13,14), (15,14).
  - ghost_blocked = 0, step_done = 0, overrun = 0, maze_addr = 0.
  - Divider = 0, FSM = IDLE.
- Divider:
  - In IDLE, each frame_tick increments the divider.
  - When the divider reaches MOVE_DIV-1 on a tick, it wraps to 0 and a sweep starts.
  - Other ticks only advance the divider.
- FSM states: IDLE, ADDR, WAIT, UPDATE, DONE.
  - IDLE -> ADDR on a sweep-starting tick. At that edge, ghost_dir is snapshotted into an internal register and ghost index g is set to 0. Direction changes mid-sweep are ignored.
  - ADDR: compute the target (tx,ty) from the current position and the snapshot direction; drive maze_addr = ty*MAZE_W + tx. Go to WAIT.
  - WAIT: hold maze_addr. Go to UPDATE.
  - UPDATE: sample maze_wall.
    - Move if direction ≠ none, maze_wall = 0 and the target is in-grid.
    - Otherwise ghost_blocked[g] = 1 when direction ≠ none, and 0 when direction = none.
    - If g = 3 go to DONE, else increment g and go to ADDR.
  - DONE: step_done = 1 for this cycle only. Go to IDLE.
- Latency:
  - Tick sampled at edge T; ghost g's position updates at edge T+3+3g.
  - step_done is high in the cycle following edge T+12 (13 cycles per sweep).
- Target rules:
  - Up: y-1. Down: y+1. Left: x-1. Right: x+1.
  - Tunnel wrap: x=0 moving left -> target x = MAZE_W-1; x = MAZE_W-1 moving right -> 0. Wall check applies to the wrapped tile.
  - Vertical out-of-grid (y=0 up, y = MAZE_H-1 down): blocked without regard to maze_wall. The memory is still addressed with the current tile so timing stays uniform.
  - Direction none: target = current tile, never moves, blocked = 0.
- Arithmetic: maze_addr computed in 10 bits. The maximum address, 867, fits. No overflow is allowed.
- frame_tick while not IDLE: ignored for movement and the divider; overrun set. overrun clears only on Reset_n or restart.
- restart:
  - Highest priority over everything except reset, in any state.
  - Positions return to start tiles; blocked, divider and overrun clear; FSM to IDLE. No step_done is issued for an aborted sweep.
- Reset_n asserted mid-sweep: immediate return to reset values; no partial position writes survive.

Decomposition:
- Package ghost_pkg:
  - typedef dir_t (3-bit) with enum DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT.
  - typedef ghost_pos_t (5-bit).
  - Constants MAZE_W, MAZE_H, NUM_GHOSTS = 4, GHOST_START_X/Y arrays.
  - FSM state enum.
- One sub-module, ghost_target_calc: combinational (x, y, dir) -> (tx, ty, out_of_grid). Wrap logic is kept here so it is reusable by the pacman mover.

Test Plan:
- MOVE_DIV=1, all dirs none, pulse frame_tick -> step_done 13 cycles later; positions unchanged; ghost_blocked = 0000.
- Ghost0 at (13,11), dir right, maze_wall=0 -> maze_addr = 11*28+14 = 322 during ghost0's ADDR/WAIT; ghost_x[0] = 14 after UPDATE.
- Ghost1 dir left with maze_wall forced 1 on its read -> ghost_x[1] stays 11; ghost_blocked[1] = 1; other ghosts unaffected.
- Tunnel wrap: ghost at (0,14) dir left, wall=0 -> addr 14*28+27 = 419, x becomes 27. Ghost at (27,14) right -> x becomes 0.
- MOVE_DIV=8 -> seven ticks produce no sweep; the eighth starts one. A second tick 5 cycles into the sweep sets overrun and does not start a new sweep.
- restart in WAIT of ghost 2 -> all positions back to start tiles, no step_done. Separately, Reset_n low mid-sweep -> all outputs return to reset values asynchronously.
